// File: rtl/acond_entradas.sv
// Input conditioning: two-flop synchronizer plus stable-count debounce for the
// temperature word, presence, ignition and activate inputs, with event pulses.
module acond_entradas #(
    parameter int STABLE_CYCLES = 1000000,
    parameter int CNT_W         = 20
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [4:0] temp_raw,
    input  logic       pres_raw,
    input  logic       carro_raw,
    input  logic       active_raw,
    output logic [4:0] temp_db,
    output logic       pres_db,
    output logic       carro_db,
    output logic       active_db,
    output logic       active_pulse,
    output logic       cambio
);

    localparam int N_CH   = 4;
    localparam int WORD_W = 5;
    localparam int CH_T   = 0;
    localparam int CH_P   = 1;
    localparam int CH_C   = 2;
    localparam int CH_A   = 3;

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(STABLE_CYCLES - 1);

    // Every channel is carried at the temperature word's width; the single-bit
    // channels keep their upper bits at a constant 0.
    logic [WORD_W-1:0] raw_w   [N_CH];
    logic [WORD_W-1:0] sync1_q [N_CH];
    logic [WORD_W-1:0] sync1_d [N_CH];
    logic [WORD_W-1:0] sync2_q [N_CH];
    logic [WORD_W-1:0] sync2_d [N_CH];
    logic [WORD_W-1:0] cand_q  [N_CH];
    logic [WORD_W-1:0] cand_d  [N_CH];
    logic [WORD_W-1:0] out_q   [N_CH];
    logic [WORD_W-1:0] out_d   [N_CH];
    logic [CNT_W-1:0]  cnt_q   [N_CH];
    logic [CNT_W-1:0]  cnt_d   [N_CH];
    logic [N_CH-1:0]   commit;
    logic              cambio_q, cambio_d;
    logic              active_pulse_q, active_pulse_d;

    assign raw_w[CH_T] = temp_raw;
    assign raw_w[CH_P] = {4'b0000, pres_raw};
    assign raw_w[CH_C] = {4'b0000, carro_raw};
    assign raw_w[CH_A] = {4'b0000, active_raw};

    always_comb begin
        // NOTE: every signal gets a default before any branch so no latch is inferred.
        for (int ch = 0; ch < N_CH; ch++) begin
            sync1_d[ch] = raw_w[ch];
            sync2_d[ch] = sync1_q[ch];
            cand_d[ch]  = cand_q[ch];
            cnt_d[ch]   = cnt_q[ch];
            out_d[ch]   = out_q[ch];
            if (sync2_q[ch] != cand_q[ch]) begin
                cand_d[ch] = sync2_q[ch];
                cnt_d[ch]  = '0;
            end else if (cnt_q[ch] == CNT_LAST) begin
                out_d[ch] = cand_q[ch];
            end else begin
                cnt_d[ch] = cnt_q[ch] + 1'b1;
            end
            commit[ch] = (out_d[ch] != out_q[ch]);
        end
    end

    // Pulses are registered so they line up with the edge that commits the level.
    always_comb begin
        cambio_d       = commit[CH_T] | commit[CH_P] | commit[CH_C];
        active_pulse_d = commit[CH_A] & ~out_q[CH_A][0];
    end

    // NOTE: sequential state uses non-blocking assignments only, so every flop
    // samples the pre-edge value of its neighbours.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int ch = 0; ch < N_CH; ch++) begin
                sync1_q[ch] <= '0;
                sync2_q[ch] <= '0;
                cand_q[ch]  <= '0;
                out_q[ch]   <= '0;
                cnt_q[ch]   <= '0;
            end
            cambio_q       <= 1'b0;
            active_pulse_q <= 1'b0;
        end else begin
            for (int ch = 0; ch < N_CH; ch++) begin
                sync1_q[ch] <= sync1_d[ch];
                sync2_q[ch] <= sync2_d[ch];
                cand_q[ch]  <= cand_d[ch];
                out_q[ch]   <= out_d[ch];
                cnt_q[ch]   <= cnt_d[ch];
            end
            cambio_q       <= cambio_d;
            active_pulse_q <= active_pulse_d;
        end
    end

    assign temp_db      = out_q[CH_T];
    assign pres_db      = out_q[CH_P][0];
    assign carro_db     = out_q[CH_C][0];
    assign active_db    = out_q[CH_A][0];
    assign cambio       = cambio_q;
    assign active_pulse = active_pulse_q;

endmodule
